// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS word registers, each read/write or read-only.
// AW and W each have a one-entry holding slot; reads return data one cycle after the address.
module axil_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [1:0]            commit_resp;
  logic [NUM_REGS-1:0]   commit_onehot;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  logic unused;
  assign unused = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0], reg_i};

  function automatic logic [DATA_WIDTH-1:0] apply_strobe(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] nxt,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = cur;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = nxt[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic is_ro(input logic [IDX_W-1:0] idx);
    logic ro;
    ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) ro = RO_MASK[i];
    end
    return ro;
  endfunction

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign arready = !rvalid || rready;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;
  // A new response may only be issued once the previous one is consumed (or is being consumed now).
  assign commit  = aw_held && w_held && (!bvalid || bready);

  assign ar_idx = araddr[ADDR_WIDTH-1:LSB];

  always_comb begin
    commit_resp   = RESP_OKAY;
    commit_onehot = '0;
    if (!in_range(aw_idx)) begin
      commit_resp = RESP_DECERR;
    end else if (is_ro(aw_idx)) begin
      commit_resp = RESP_SLVERR;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) commit_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_resp = RESP_OKAY;
        rd_data = RO_MASK[i] ? reg_i[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
    assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs[g];
  end

  // Holding slots: flags are control state, captured address/data need no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (commit)       aw_held <= 1'b0;
      else if (aw_fire) aw_held <= 1'b1;
      if (commit)       w_held  <= 1'b0;
      else if (w_fire)  w_held  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) aw_idx <= awaddr[ADDR_WIDTH-1:LSB];
    if (w_fire) begin
      w_data <= wdata;
      w_strb <= wstrb;
    end
  end

  // Commit stage: register update, write response and write pulse all land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && commit_resp == RESP_OKAY) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_onehot[i]) regs[i] <= apply_strobe(regs[i], w_data, w_strb);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= commit_resp;
        if (commit_resp == RESP_OKAY) wr_pulse_o <= commit_onehot;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read stage: one-cycle registered response; regs here still hold pre-commit values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_resp;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
